// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: widths, status flags, result entry, occupancy
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  typedef struct packed {
    logic zero;
    logic neg;
    logic parity;
  } alu_flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [SEL_W-1:0]  sel;
    alu_flags_t        flags;
  } alu_entry_t;

  // Result stage occupancy: how many of the two entries hold valid data
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } alu_occ_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational zero/negative/parity flags for a logic unit result
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  // Flags are pure functions of the result; parity is 1 for an odd number of ones
  always_comb begin
    flags        = '0;
    flags.zero   = (result == '0);
    flags.neg    = result[DATA_W-1];
    flags.parity = ^result;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU output stage with 2-entry skid buffer and status flags
module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_parity,
  input  logic              clr_sticky,
  output logic              sticky_zero,
  output logic [CNT_W-1:0]  result_count
);

  import alu_pkg::*;

  alu_occ_t   occ_q, occ_d;
  alu_entry_t main_q, skid_q;
  alu_entry_t in_entry;
  alu_flags_t in_flags;
  logic       accept, drain;
  logic       load_main_in, load_main_skid, load_skid;

  // Flags are derived before registering so they always travel with their result
  alu_flag_gen u_flag_gen (
    .result (in_result),
    .flags  (in_flags)
  );

  assign in_entry = '{result: in_result, sel: in_sel, flags: in_flags};

  // in_ready comes straight from occupancy state, so there is no path from out_ready
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  assign out_result = main_q.result;
  assign out_sel    = main_q.sel;
  assign out_zero   = main_q.flags.zero;
  assign out_neg    = main_q.flags.neg;
  assign out_parity = main_q.flags.parity;

  // Occupancy next state and entry load selects
  always_comb begin
    occ_d          = occ_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          occ_d        = OCC_ONE;
          load_main_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          occ_d     = OCC_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (drain) begin
          occ_d          = OCC_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= OCC_EMPTY;
    else     occ_q <= occ_d;
  end

  // Entry registers; a held main entry only changes on an explicit load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  // Sticky zero: a zero-result accept takes priority over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  sticky_zero <= 1'b0;
    else if (accept && (in_result == '0))     sticky_zero <= 1'b1;
    else if (clr_sticky)                      sticky_zero <= 1'b0;
  end

  // Accepted-result counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         result_count <= '0;
    else if (accept) result_count <= result_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed and scoreboarded bench for alu_result_stage
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic        out_parity;
  logic        clr_sticky;
  logic        sticky_zero;
  logic [7:0]  result_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  sel;
    logic        zero;
    logic        neg;
    logic        parity;
  } vec_t;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  s;
  } ent_t;

  vec_t       vecs[8];
  ent_t       sb[$];
  ent_t       front;
  logic [7:0] exp_count;
  bit         acc, drn;

  alu_result_stage #(.DATA_W(16), .SEL_W(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_sel       (in_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_sel      (out_sel),
    .out_zero     (out_zero),
    .out_neg      (out_neg),
    .out_parity   (out_parity),
    .clr_sticky   (clr_sticky),
    .sticky_zero  (sticky_zero),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_parity(input logic [15:0] v);
    int ones = 0;
    for (int b = 0; b < 16; b++) if (v[b]) ones++;
    return (ones % 2) == 1;
  endfunction

  initial begin
    vecs[0] = '{16'h8001, 4'hE, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h00FF, 4'h3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h0001, 4'h1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 4'hF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFE, 4'h5, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 4'hA, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 4'h7, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_sel = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    #12 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_neg", out_neg, 0);
    check("rst_out_parity", out_parity, 0);
    check("rst_sticky", sticky_zero, 0);
    check("rst_count", result_count, 0);

    // Single-pass table: each vector visible the cycle after its accept
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_result = vecs[i].res; in_sel = vecs[i].sel;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      check($sformatf("vec%0d_sel", i), out_sel, vecs[i].sel);
      check($sformatf("vec%0d_zero", i), out_zero, vecs[i].zero);
      check($sformatf("vec%0d_neg", i), out_neg, vecs[i].neg);
      check($sformatf("vec%0d_parity", i), out_parity, vecs[i].parity);
    end
    tick();
    check("table_drained", out_valid, 0);
    check("table_count", result_count, 8);
    check("table_sticky", sticky_zero, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("clr_after_table", sticky_zero, 0);

    // Sticky: set beats clear in the same cycle
    in_valid = 1'b1; in_result = 16'h0000; in_sel = 4'h2;
    tick();
    check("sticky_set", sticky_zero, 1);
    check("sticky_out_zero", out_zero, 1);
    clr_sticky = 1'b1;
    tick();
    check("sticky_set_wins", sticky_zero, 1);
    in_valid = 1'b0;
    tick();
    clr_sticky = 1'b0;
    check("sticky_cleared", sticky_zero, 0);
    tick();
    check("sticky_drained", out_valid, 0);

    // Back-pressure: two accepts fill both entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 16'h00FF; in_sel = 4'h4;
    tick();
    check("bp_ready_one", in_ready, 1);
    in_result = 16'h0001; in_sel = 4'h6;
    tick();
    in_valid = 1'b0;
    check("bp_ready_full", in_ready, 0);
    check("bp_hold_result", out_result, 16'h00FF);
    tick();
    check("bp_hold_result2", out_result, 16'h00FF);
    check("bp_hold_sel", out_sel, 4'h4);
    check("bp_hold_parity", out_parity, 0);
    out_ready = 1'b1;
    tick();
    check("bp_second_result", out_result, 16'h0001);
    check("bp_second_sel", out_sel, 4'h6);
    check("bp_second_valid", out_valid, 1);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_count", result_count, 12);

    // Asynchronous reset with both entries occupied
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 16'h0000; in_sel = 4'h1;
    tick();
    in_result = 16'h1234; in_sel = 4'h2;
    tick();
    in_valid = 1'b0;
    check("prerst_full", in_ready, 0);
    check("prerst_sticky", sticky_zero, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_sticky", sticky_zero, 0);
    check("arst_count", result_count, 0);
    #1 rst = 1'b0;
    tick();
    check("arst_still_empty", out_valid, 0);

    // Streaming: one result per cycle, counter wraps past 256
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_result = 16'(i); in_sel = 4'(i);
      tick();
      check($sformatf("stream%0d_valid", i), out_valid, 1);
      check($sformatf("stream%0d_result", i), out_result, 16'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", out_valid, 0);
    check("stream_count", result_count, 44);

    // Random handshakes against a FIFO scoreboard and flag model
    exp_count = 8'd44;
    for (int c = 0; c < 10000; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_result  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) in_result = 16'h0000;
      in_sel     = 4'($urandom);
      out_ready  = 1'($urandom_range(0, 1));
      #2;
      check("rnd_in_ready", in_ready, sb.size() < 2);
      check("rnd_out_valid", out_valid, sb.size() != 0);
      acc = in_valid && (sb.size() < 2);
      drn = out_ready && (sb.size() != 0);
      if (drn) begin
        front = sb.pop_front();
        check("rnd_result", out_result, front.r);
        check("rnd_sel", out_sel, front.s);
        check("rnd_zero", out_zero, front.r == 16'h0000);
        check("rnd_neg", out_neg, front.r[15]);
        check("rnd_parity", out_parity, ref_parity(front.r));
      end
      if (acc) begin
        sb.push_back('{r: in_result, s: in_sel});
        exp_count = exp_count + 8'd1;
      end
      tick();
    end
    in_valid = 1'b0;
    check("rnd_count", result_count, exp_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
